// File: rtl/irb_pkg.sv
// ----------------------------------------------------------------------------
// irb_pkg
// Shared types and constants for the image result buffer (IRB) capture block.
//   irb_state_t   : capture FSM state encoding
//   IRB_DEPTH     : number of bytes in one 8x8 frame
//   IRB_LAST_ADDR : highest valid IRB address
//   crc8_step     : one-byte CRC-8 update (poly 0x07, MSB-first)
// Optional feature macro used by the capture block: IRB_CAPTURE_CRC_EN.
// ----------------------------------------------------------------------------
package irb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        READY   = 2'd3
    } irb_state_t;

    localparam int         IRB_DEPTH     = 64;
    localparam logic [5:0] IRB_LAST_ADDR = 6'd63;

    // Fold the byte into the CRC register, then shift out eight bits,
    // applying the polynomial whenever a 1 falls off the top.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/irb_mem.sv
// ----------------------------------------------------------------------------
// irb_mem
// Single-write / single-read synchronous RAM holding one IRB frame.
// Read data is registered and holds when no read is requested. A read of a
// location written in the same cycle returns the previous contents.
// Ports:
//   clk, reset        : clock, synchronous active-low reset (clears rdata only)
//   we, waddr, wdata  : write port
//   re, raddr, rdata  : read request / address / registered data
// ----------------------------------------------------------------------------
module irb_mem #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/irb_capture.sv
// ----------------------------------------------------------------------------
// irb_capture
// Sink for the IRB write interface: captures one 64-byte frame, checks that
// addresses arrive in order (0,1,2,...) and that the frame is complete, and
// accumulates a byte checksum. The frame is held for readout until clear.
//
// Handshake: IRB_RW==0 is a write strobe for exactly that cycle; there is no
// back-pressure. A strobe is accepted only in IDLE/CAPTURE, only while fewer
// than 64 writes have been accepted, and never in a cycle with clear.
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   IRB_RW/IRB_A/IRB_D  : write strobe (active low), address, data
//   done                : frame-complete level from the controller
//   clear               : one-cycle pulse, discards frame, back to IDLE
//   rd_en/rd_addr       : readout request; rd_data valid the next cycle
//   frame_ready         : frame accepted, memory and checksum stable
//   checksum            : unsigned sum of accepted bytes
//   err_order/err_short : sticky address-order / incomplete-frame flags
//   fsm_state           : debug view of the capture FSM state
//   wr_count            : accepted writes (0..64)
//   crc8                : CRC-8 of accepted bytes (only with IRB_CAPTURE_CRC_EN)
// ----------------------------------------------------------------------------
module irb_capture
    import irb_pkg::*;
#(
    parameter int AW  = 6,
    parameter int DW  = 8,
    parameter int CSW = 14
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           IRB_RW,
    input  logic [AW-1:0]  IRB_A,
    input  logic [DW-1:0]  IRB_D,
    input  logic           done,
    input  logic           clear,
    input  logic           rd_en,
    input  logic [AW-1:0]  rd_addr,
    output logic [DW-1:0]  rd_data,
    output logic           frame_ready,
    output logic [CSW-1:0] checksum,
    output logic           err_order,
    output logic           err_short,
    output irb_state_t     fsm_state,
    output logic [AW:0]    wr_count
`ifdef IRB_CAPTURE_CRC_EN
    ,
    output logic [7:0]     crc8
`endif
);

    irb_state_t    state, next_state;
    logic [AW-1:0] last_addr;
    logic          accept;
    logic          order_bad;
    logic          frame_full;

    assign fsm_state  = state;
    assign frame_full = (wr_count == (AW+1)'(IRB_DEPTH));

    always_comb begin
        accept    = 1'b0;
        order_bad = 1'b0;
        if (!IRB_RW && !clear && !frame_full &&
            (state == IDLE || state == CAPTURE)) begin
            accept = 1'b1;
        end
        // The first write of a frame must be address 0; later writes must
        // follow the previous accepted address (wrapping at the top).
        if (state == IDLE) order_bad = (IRB_A != '0);
        else               order_bad = (IRB_A != AW'(last_addr + 1'b1));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (done)        next_state = CHECK;
                else if (accept) next_state = CAPTURE;
            end
            CAPTURE: if (done) next_state = CHECK;
            CHECK:   next_state = READY;
            READY:   next_state = READY;
            default: next_state = IDLE;
        endcase
        if (clear) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            checksum    <= '0;
            wr_count    <= '0;
            err_order   <= 1'b0;
            err_short   <= 1'b0;
            frame_ready <= 1'b0;
            last_addr   <= '0;
        end else begin
            state       <= next_state;
            frame_ready <= (next_state == READY);
            if (clear) begin
                checksum  <= '0;
                wr_count  <= '0;
                err_order <= 1'b0;
                err_short <= 1'b0;
                last_addr <= '0;
            end else begin
                if (accept) begin
                    checksum  <= checksum + CSW'(IRB_D);
                    wr_count  <= wr_count + 1'b1;
                    last_addr <= IRB_A;
                    if (order_bad) err_order <= 1'b1;
                end
                if (state == CHECK && !frame_full) err_short <= 1'b1;
            end
        end
    end

`ifdef IRB_CAPTURE_CRC_EN
    always_ff @(posedge clk) begin
        if (!reset || clear) crc8 <= 8'h00;
        else if (accept)     crc8 <= crc8_step(crc8, IRB_D);
    end
`endif

    irb_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (IRB_A),
        .wdata (IRB_D),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_irb_capture.sv
module tb_irb_capture;
    import irb_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       IRB_RW = 1'b1;
    logic [5:0] IRB_A = '0;
    logic [7:0] IRB_D = '0;
    logic       done = 1'b0;
    logic       clear = 1'b0;
    logic       rd_en = 1'b0;
    logic [5:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic [13:0] checksum;
    logic       err_order;
    logic       err_short;
    irb_state_t fsm_state;
    logic [6:0] wr_count;
`ifdef IRB_CAPTURE_CRC_EN
    logic [7:0] crc8;
`endif

    always #5 clk = ~clk;

    irb_capture dut (
        .clk         (clk),
        .reset       (reset),
        .IRB_RW      (IRB_RW),
        .IRB_A       (IRB_A),
        .IRB_D       (IRB_D),
        .done        (done),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .checksum    (checksum),
        .err_order   (err_order),
        .err_short   (err_short),
        .fsm_state   (fsm_state),
        .wr_count    (wr_count)
`ifdef IRB_CAPTURE_CRC_EN
        ,
        .crc8        (crc8)
`endif
    );

    // status vector: {frame_ready, err_order, err_short, wr_count, checksum}
    wire [23:0] st = {frame_ready, err_order, err_short, wr_count, checksum};

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- model / scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [7:0]  model_mem [64];
    logic [13:0] exp_sum;
    logic [6:0]  exp_cnt;
    logic [7:0]  exp_crc;
    logic [7:0]  last_rd;
    logic        rd_pend = 1'b0;

    // Bit-serial CRC-8, poly 0x07, MSB first.
    function automatic logic [7:0] tb_crc(input logic [7:0] crc, input logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[7] ^ d[i];
            crc = {crc[6:0], 1'b0};
            if (fb) crc = crc ^ 8'h07;
        end
        return crc;
    endfunction

    always @(posedge clk) rd_pend <= rd_en & reset;

    always @(negedge clk) begin
        if (rd_pend) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %h, no read expected", rd_data);
            end else begin
                last_rd = exp_q.pop_front();
                if (rd_data !== last_rd) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h want %h", rd_data, last_rd);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_sum = '0;
        exp_cnt = '0;
        exp_crc = '0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d, input bit acc);
        IRB_RW = 1'b0;
        IRB_A  = a;
        IRB_D  = d;
        step();
        IRB_RW = 1'b1;
        if (acc) begin
            model_mem[a] = d;
            exp_sum      = exp_sum + 14'(d);
            exp_cnt      = exp_cnt + 7'd1;
            exp_crc      = tb_crc(exp_crc, d);
        end
    endtask

    task automatic rd(input logic [5:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(model_mem[a]);
        step();
        rd_en = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if (st !== 24'h0) begin
            n_fail++; $display("FAIL reset_status: got %h want %h", st, 24'h0);
        end
        n_checks++;
        if (fsm_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE);
        end
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data);
        end
        reset = 1'b1;
        step();
        model_reset();
    endtask

    task automatic test_ordered_frame();
        for (int i = 0; i < 64; i++) wr(6'(i), 8'(i), 1'b1);
        n_checks++;
        if (fsm_state !== CAPTURE || wr_count !== 7'd64) begin
            n_fail++; $display("FAIL ordered_full: got state %0d cnt %0d want 1/64", fsm_state, wr_count);
        end
        wr(6'd0, 8'h55, 1'b0);            // 65th write must be ignored
        n_checks++;
        if (st !== {3'b000, 7'd64, 14'd2016}) begin
            n_fail++; $display("FAIL ordered_overflow: got %h want %h", st, {3'b000, 7'd64, 14'd2016});
        end
        pulse_done();
        n_checks++;
        if (fsm_state !== CHECK || frame_ready !== 1'b0) begin
            n_fail++; $display("FAIL ordered_check: got state %0d ready %b want 2/0", fsm_state, frame_ready);
        end
        step();
        n_checks++;
        if (st !== {3'b100, 7'd64, 14'd2016} || fsm_state !== READY) begin
            n_fail++; $display("FAIL ordered_ready: got %h state %0d want %h state 3", st, fsm_state, {3'b100, 7'd64, 14'd2016});
        end
        wr(6'd1, 8'hAA, 1'b0);            // writes in READY are ignored
        n_checks++;
        if (wr_count !== 7'd64 || checksum !== 14'd2016) begin
            n_fail++; $display("FAIL ready_write: got cnt %0d sum %0d want 64/2016", wr_count, checksum);
        end
        rd(6'h2A);
        step();
        n_checks++;
        if (rd_data !== 8'h2A) begin
            n_fail++; $display("FAIL rd_hold: got %h want 2a", rd_data);
        end
        rd(6'd0);
        rd(6'd1);
        pulse_clear();
        n_checks++;
        if (st !== 24'h0 || fsm_state !== IDLE) begin
            n_fail++; $display("FAIL ordered_clear: got %h state %0d want 0 state 0", st, fsm_state);
        end
    endtask

    task automatic test_ff_frame();
        for (int i = 0; i < 64; i++) wr(6'(i), 8'hFF, 1'b1);
        pulse_done();
        step();
        n_checks++;
        if (st !== {3'b100, 7'd64, 14'd16320}) begin
            n_fail++; $display("FAIL ff_sum: got %h want %h", st, {3'b100, 7'd64, 14'd16320});
        end
`ifdef IRB_CAPTURE_CRC_EN
        n_checks++;
        if (crc8 !== exp_crc) begin
            n_fail++; $display("FAIL ff_crc: got %h want %h", crc8, exp_crc);
        end
`endif
        rd(6'd63);
        pulse_clear();
`ifdef IRB_CAPTURE_CRC_EN
        n_checks++;
        if (crc8 !== 8'h00) begin
            n_fail++; $display("FAIL crc_clear: got %h want 00", crc8);
        end
`endif
    endtask

    task automatic test_short();
        for (int i = 0; i < 32; i++) wr(6'(i), 8'($urandom_range(0, 255)), 1'b1);
        pulse_done();
        step();
        n_checks++;
        if (st !== {3'b101, 7'd32, exp_sum}) begin
            n_fail++; $display("FAIL short: got %h want %h", st, {3'b101, 7'd32, exp_sum});
        end
`ifdef IRB_CAPTURE_CRC_EN
        n_checks++;
        if (crc8 !== exp_crc) begin
            n_fail++; $display("FAIL short_crc: got %h want %h", crc8, exp_crc);
        end
`endif
        for (int i = 0; i < 4; i++) rd(6'($urandom_range(0, 31)));
        pulse_clear();
    endtask

    task automatic test_done_idle();
        pulse_done();
        step();
        n_checks++;
        if (st !== {3'b101, 7'd0, 14'd0}) begin
            n_fail++; $display("FAIL done_idle: got %h want %h", st, {3'b101, 7'd0, 14'd0});
        end
        pulse_clear();
    endtask

    task automatic test_order_err();
        wr(6'd0, 8'd10, 1'b1);
        wr(6'd1, 8'd11, 1'b1);
        n_checks++;
        if (err_order !== 1'b0) begin
            n_fail++; $display("FAIL order_early: got %b want 0", err_order);
        end
        wr(6'd3, 8'd13, 1'b1);
        n_checks++;
        if (err_order !== 1'b1) begin
            n_fail++; $display("FAIL order_skip: got %b want 1", err_order);
        end
        for (int i = 4; i <= 10; i++) wr(6'(i), 8'($urandom_range(0, 255)), 1'b1);
        pulse_done();
        step();
        step();
        step();
        n_checks++;
        if (st !== {3'b111, exp_cnt, exp_sum}) begin
            n_fail++; $display("FAIL order_ready: got %h want %h", st, {3'b111, exp_cnt, exp_sum});
        end
        pulse_clear();
        n_checks++;
        if (err_order !== 1'b0 || fsm_state !== IDLE) begin
            n_fail++; $display("FAIL order_clear: got err %b state %0d want 0/0", err_order, fsm_state);
        end
        wr(6'd5, 8'd1, 1'b1);             // first write not at address 0
        n_checks++;
        if (err_order !== 1'b1 || fsm_state !== CAPTURE) begin
            n_fail++; $display("FAIL order_first: got err %b state %0d want 1/1", err_order, fsm_state);
        end
        pulse_clear();
        wr(6'd0, 8'h21, 1'b1);
        wr(6'd1, 8'h32, 1'b1);
        wr(6'd1, 8'h43, 1'b1);            // duplicate address
        n_checks++;
        if (st !== {3'b010, 7'd3, 14'h96}) begin
            n_fail++; $display("FAIL dup: got %h want %h", st, {3'b010, 7'd3, 14'h96});
        end
        rd(6'd1);
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 40; i++) wr(6'(i), 8'($urandom_range(0, 255)), 1'b1);
        IRB_RW = 1'b0;
        IRB_A  = 6'd40;
        IRB_D  = 8'hEE;
        reset  = 1'b0;
        step();
        IRB_RW = 1'b1;
        reset  = 1'b1;
        model_reset();
        n_checks++;
        if (st !== 24'h0 || fsm_state !== IDLE) begin
            n_fail++; $display("FAIL mid_reset: got %h state %0d want 0 state 0", st, fsm_state);
        end
        for (int i = 0; i < 64; i++) wr(6'(i), 8'(i), 1'b1);
        pulse_done();
        step();
        n_checks++;
        if (st !== {3'b100, 7'd64, 14'd2016}) begin
            n_fail++; $display("FAIL mid_frame: got %h want %h", st, {3'b100, 7'd64, 14'd2016});
        end
        rd(6'h2A);
        rd(6'd39);
        pulse_clear();
    endtask

    task automatic test_clear_write();
        IRB_RW = 1'b0; IRB_A = 6'd0; IRB_D = 8'h77; clear = 1'b1;
        step();
        IRB_RW = 1'b1; clear = 1'b0;
        n_checks++;
        if (st !== 24'h0 || fsm_state !== IDLE) begin
            n_fail++; $display("FAIL clear_wr_idle: got %h state %0d want 0 state 0", st, fsm_state);
        end
        rd(6'd0);                         // dropped write left old data
        wr(6'd0, 8'h01, 1'b1);
        wr(6'd1, 8'h02, 1'b1);
        IRB_RW = 1'b0; IRB_A = 6'd2; IRB_D = 8'h66; clear = 1'b1;
        step();
        IRB_RW = 1'b1; clear = 1'b0;
        model_reset();
        n_checks++;
        if (st !== 24'h0 || fsm_state !== IDLE) begin
            n_fail++; $display("FAIL clear_wr_cap: got %h state %0d want 0 state 0", st, fsm_state);
        end
        rd(6'd2);
        // read and write of the same address in one cycle: old data returns
        rd_en = 1'b1; rd_addr = 6'd5;
        exp_q.push_back(model_mem[5]);
        wr(6'd5, 8'h99, 1'b0);            // address 5 first: order error, still accepted
        rd_en = 1'b0;
        model_mem[5] = 8'h99;
        rd(6'd5);
        pulse_clear();
    endtask

    task automatic test_write_with_done();
        for (int i = 0; i < 63; i++) wr(6'(i), 8'($urandom_range(0, 255)), 1'b1);
        done = 1'b1;
        wr(6'd63, 8'hC3, 1'b1);
        done = 1'b0;
        n_checks++;
        if (fsm_state !== CHECK || wr_count !== 7'd64) begin
            n_fail++; $display("FAIL wr_done: got state %0d cnt %0d want 2/64", fsm_state, wr_count);
        end
        step();
        n_checks++;
        if (st !== {3'b100, 7'd64, exp_sum}) begin
            n_fail++; $display("FAIL wr_done_ready: got %h want %h", st, {3'b100, 7'd64, exp_sum});
        end
        rd(6'd63);
        rd(6'($urandom_range(0, 62)));
        pulse_clear();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = 8'(i);
        model_reset();
        test_reset();
        test_ordered_frame();
        test_ff_frame();
        test_short();
        test_done_idle();
        test_order_err();
        test_reset_mid();
        test_clear_write();
        test_write_with_done();
        step();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rd_drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irb_capture.md
Name: irb_capture

Overview:
- Responder/sink on the IRB write interface driven by the LCD controller; models the image result buffer.
- Captures the 64-byte (8x8) output frame, checks address ordering and completeness, and computes a checksum.
- Exposes a frame-ready flag and a 1-cycle-latency readout port for downstream checking and display logic.

Parameters:
- AW, 6, IRB address width; depth is 2**AW = 64 bytes.
- DW, 8, pixel data width.
- CSW, 14, checksum width; holds 64*255 = 16320 without overflow.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- IRB_RW  in  1  0 = write strobe for this cycle; 1 = idle.
- IRB_A  in  AW  write address.
- IRB_D  in  DW  write data.
- done  in  1  controller frame-complete level.
- clear  in  1  one-cycle pulse; discards the frame and returns to IDLE.
- rd_en  in  1  readout request.
- rd_addr  in  AW  readout address.
- rd_data  out  DW  readout data, valid the cycle after rd_en.
- frame_ready  out  1  frame accepted; memory and checksum stable.
- checksum  out  CSW  unsigned sum of all captured bytes.
- err_order  out  1  sticky: an address was not previous+1.
- err_short  out  1  sticky: done arrived before 64 writes.
- wr_count  out  AW+1  number of writes accepted (0..64).

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all outputs 0; memory contents are don't-care. A reset mid-capture aborts the frame with no residue.
- A write is accepted when IRB_RW==0 and state is IDLE or CAPTURE: mem[IRB_A] <= IRB_D.
- In IDLE or CAPTURE, each accepted write also does: checksum += IRB_D (zero-extended), wr_count += 1.
- States:
  - IDLE: waits. An accepted write moves to CAPTURE. If that first write has IRB_A != 0, err_order is set.
  - CAPTURE: every accepted write compares IRB_A against last_addr+1 (6-bit wrap) and sets err_order on mismatch.
    - When wr_count reaches 64, further writes are ignored and do not count. Exception: a write in the same cycle as the 64th completion is ignored.
    - done==1 moves to CHECK. A write in the same cycle as done is still accepted.
  - CHECK: one cycle. Sets err_short if wr_count<64. Moves to READY.
  - READY: frame_ready=1. IRB writes are ignored. Stays until clear.
- clear in any state: returns to IDLE next cycle and zeroes checksum, wr_count, both err flags, frame_ready and last_addr. clear has priority over a simultaneous write, which is dropped.
- done seen in IDLE (zero writes): goes to CHECK, then sets err_short, and frame_ready=1 with wr_count=0.
- Duplicate address: the memory overwrites, checksum includes both values, and err_order is set.
- Readout: rd_data <= mem[rd_addr] on any cycle rd_en==1, in any state. If rd_en==0, rd_data holds its value. Reading a location written in the same cycle returns the old data.
- All outputs are registered.

Optional Feature:
- Macro IRB_CAPTURE_CRC_EN.
- Defined: adds output crc8 [7:0], a CRC-8 (poly 0x07, init 0x00, MSB-first, one byte per cycle) over accepted writes in acceptance order. crc8 clears with reset and with clear, and is stable while frame_ready.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package irb_pkg holds:
  - state typedef {IDLE, CAPTURE, CHECK, READY};
  - constants IRB_DEPTH=64 and IRB_LAST_ADDR=6'd63;
  - function crc8_step(crc, byte).
- One sub-module is natural: irb_mem, a 64x8 single-write/single-read synchronous RAM with registered read.

Test Plan:
- Write addresses 0..63 in order, data = address, then done -> frame_ready=1, checksum=2016, wr_count=64, both err flags 0. Readout of 0x2A gives rd_data=0x2A one cycle later.
- Write 0..63 with data 0xFF -> checksum=16320, no overflow. With IRB_CAPTURE_CRC_EN, crc8 matches the golden model value.
- Write 0..31 then done -> err_short=1, wr_count=32, frame_ready=1.
- Write sequence 0,1,3,... -> err_order=1 and remains 1 through READY; clear -> err_order=0, state IDLE.
- Assert reset at write 40, then run a clean frame of 0..63 -> results equal the first test with no residue.
- clear and a write in the same cycle -> write dropped, wr_count=0. A write in the same cycle as done -> accepted and counted.
